axis_seg_header_strip: RTL and testbench
========================================

Name: axis_seg_header_strip

Overview:
- Sits directly downstream of the segmented-output shift FIFO.
- Consumes that FIFO's independent per-segment lanes and discards the first strip_segs segments of every packet (segment-granular header removal).
- Re-emits the remaining payload as a full-width, left-aligned AXI Stream through one output register.
- Rotation uses independent lane popping: output lane i draws from input lane (i+off) mod NUM_SEGMENTS. Input lanes below off therefore run one row ahead of the others.

Parameters:
AXIS_BUS_WIDTH, 64, bus width in bits
AXIS_USER_WIDTH, 4, tuser width
NUM_SEGMENTS, 4, segments per beat (power of 2, >=2)
(derived) AXIS_SEG_WIDTH = AXIS_BUS_WIDTH/NUM_SEGMENTS; NUM_SEG_BYTES = AXIS_SEG_WIDTH/8; NUM_BUS_BYTES = AXIS_BUS_WIDTH/8; OFF_BITS = clog2(NUM_SEGMENTS)

Ports:
aclk  in  1  clock (single clock domain)
aresetn  in  1  asynchronous, active-low reset
strip_segs  in  OFF_BITS  segments to strip; sampled at packet start
axis_in_tdata  in  [AXIS_SEG_WIDTH] x NUM_SEGMENTS  per-lane head data
axis_in_tkeep  in  [NUM_SEG_BYTES] x NUM_SEGMENTS  per-lane head keep
axis_in_next_tkeep  in  [NUM_SEG_BYTES] x NUM_SEGMENTS  per-lane second-entry keep
axis_in_tuser  in  AXIS_USER_WIDTH  user of lane NUM_SEGMENTS-1 head row
axis_in_tlast  in  1  last flag of lane NUM_SEGMENTS-1 head row
axis_in_tvalid  in  1 x NUM_SEGMENTS  per-lane non-empty
axis_in_tready  out  1 x NUM_SEGMENTS  per-lane pop
axis_out_tdata  out  AXIS_BUS_WIDTH
axis_out_tkeep  out  NUM_BUS_BYTES
axis_out_tuser  out  AXIS_USER_WIDTH
axis_out_tlast  out  1
axis_out_tvalid  out  1
axis_out_tready  in  1

Behaviour:
- Input contract: packets start row-aligned; tkeep is contiguous from byte 0; only the tlast row may be partial. Trailing segments of the tlast row carry tkeep 0.
- Reset: async clear of all output regs and state. axis_out_tvalid, tdata, tkeep, tuser and tlast reset to 0. State resets to STRIP and off to 0. axis_in_tready is all 0 during reset.
- Output register "free" = !axis_out_tvalid || axis_out_tready. Inputs are popped only when free. Latency is 1 cycle from the pop cycle to axis_out_tvalid.
- axis_in_tready[j] is combinational from state and valids. Popping a lane whose tvalid=0 is forbidden.
- STRIP:
  - off <= strip_segs; tuser is captured from axis_in_tuser.
  - When lanes 0..off-1 are all valid, pop them and discard the data. Go to STREAM.
  - If off=0, go to STREAM with no pop.
  - Header-only packet: lane N-1 tlast=1 and tkeep[off]==0. Pop all lanes, emit nothing, stay in STRIP.
  - The strip step takes 1 cycle and does not require free.
- STREAM, beat ready when all lanes valid (or lanes off..N-1 valid if lane N-1 tlast=1) and free:
  - Output lane i = input lane (i+off) mod N; tuser = captured value.
  - Case A, lane N-1 tlast=1: lanes sourced from lanes 0..off-1 get tkeep 0. Pop only lanes off..N-1. Set tlast=1 and go to STRIP.
  - Case B, off!=0 and axis_in_next_tkeep[off]==0 (next row has no bytes at or above off): pop all lanes, set tlast=1, go to DRAIN.
    - Validity of next_tkeep[off] is guaranteed because lanes 0..off-1 already hold that row.
  - Otherwise: pop all lanes, tlast=0.
- DRAIN: when lanes off..N-1 are valid, pop them (empty remainder of the tlast row) and go to STRIP. DRAIN does not require free.
- Backpressure: while axis_out_tvalid && !axis_out_tready, the output holds stable and no STREAM pops occur.
- strip_segs changes outside STRIP are ignored.
- Reset mid-packet abandons the packet. The upstream FIFO is reset by the same aresetn.

Test Plan:
1. N=4, off=0, 3 full rows, R2 tlast -> 3 beats identical to input rows, tkeep 0xFF, tlast only on beat 3, first tvalid 1 cycle after pop.
2. off=1, rows R0..R2 full, R2 tlast -> beats {R0s1,R0s2,R0s3,R1s0} 0xFF; {R1s1..3,R2s0} 0xFF; {R2s1..3,-} tkeep 0x3F tlast=1 (Case A).
3. off=2, R0 full, R1 tkeep 0x03 tlast -> single beat {R0s2,R0s3,R1s0,R1s1} tkeep 0x3F tlast=1 (Case B). DRAIN pops R1 lanes 2,3. Next packet with off=0 passes through unrotated.
4. off=2, single row tkeep 0x0F tlast -> no output beat; following 2-row packet is emitted correctly.
5. axis_out_tready low for 5 cycles mid-packet -> output stable, axis_in_tready all 0 in STREAM. Then resume with no loss or duplication. strip_segs toggled mid-packet -> no effect.
6. aresetn asserted asynchronously mid-packet -> tvalid=0 immediately, state STRIP. New packet after release is stripped with the fresh strip_segs.

Source files
------------

// File: rtl/axis_seg_header_strip.sv
// axis_seg_header_strip: drops the first strip_segs segments of every packet from a per-lane
// segmented FIFO and re-emits the payload as a left-aligned, registered AXI Stream.
module axis_seg_header_strip #(
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_USER_WIDTH = 4,
    parameter int NUM_SEGMENTS    = 4,
    localparam int AXIS_SEG_WIDTH = AXIS_BUS_WIDTH / NUM_SEGMENTS,
    localparam int NUM_SEG_BYTES  = AXIS_SEG_WIDTH / 8,
    localparam int NUM_BUS_BYTES  = AXIS_BUS_WIDTH / 8,
    localparam int OFF_BITS       = $clog2(NUM_SEGMENTS)
) (
    input  logic                                    aclk,
    input  logic                                    aresetn,
    input  logic [OFF_BITS-1:0]                     strip_segs,
    input  logic [NUM_SEGMENTS*AXIS_SEG_WIDTH-1:0]  axis_in_tdata,
    input  logic [NUM_SEGMENTS*NUM_SEG_BYTES-1:0]   axis_in_tkeep,
    input  logic [NUM_SEGMENTS*NUM_SEG_BYTES-1:0]   axis_in_next_tkeep,
    input  logic [AXIS_USER_WIDTH-1:0]              axis_in_tuser,
    input  logic                                    axis_in_tlast,
    input  logic [NUM_SEGMENTS-1:0]                 axis_in_tvalid,
    output logic [NUM_SEGMENTS-1:0]                 axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]               axis_out_tdata,
    output logic [NUM_BUS_BYTES-1:0]                axis_out_tkeep,
    output logic [AXIS_USER_WIDTH-1:0]              axis_out_tuser,
    output logic                                    axis_out_tlast,
    output logic                                    axis_out_tvalid,
    input  logic                                    axis_out_tready
);
    typedef enum logic [1:0] {STRIP, STREAM, DRAIN} state_t;
    localparam logic [NUM_SEGMENTS-1:0] ALL_LANES = '1;

    state_t                         r_state, w_next;
    logic [OFF_BITS-1:0]            r_off, w_off;
    logic [AXIS_USER_WIDTH-1:0]     r_tuser;
    logic [AXIS_BUS_WIDTH-1:0]      r_tdata, w_tdata;
    logic [NUM_BUS_BYTES-1:0]       r_tkeep, w_tkeep;
    logic [AXIS_USER_WIDTH-1:0]     r_out_tuser;
    logic                           r_tlast, r_tvalid;
    logic [NUM_SEGMENTS-1:0]        w_lo_mask, w_hi_mask, w_pop;
    logic                           w_free, w_all, w_hi_valid, w_last, w_hdr_only, w_case_b, w_beat;

    // In STRIP the new offset is live on strip_segs; afterwards the captured copy rules.
    assign w_off      = (r_state == STRIP) ? strip_segs : r_off;
    assign w_lo_mask  = (NUM_SEGMENTS'(1) << w_off) - NUM_SEGMENTS'(1);
    assign w_hi_mask  = ~w_lo_mask;
    assign w_free     = !r_tvalid || axis_out_tready;
    assign w_all      = &axis_in_tvalid;
    assign w_hi_valid = &(axis_in_tvalid | w_lo_mask);
    assign w_last     = axis_in_tvalid[NUM_SEGMENTS-1] && axis_in_tlast;
    assign w_hdr_only = w_all && axis_in_tlast &&
                        (axis_in_tkeep[int'(w_off)*NUM_SEG_BYTES +: NUM_SEG_BYTES] == '0);
    // Lanes below off already hold the next row; an empty lane off there means it is the tail.
    assign w_case_b   = !w_last && w_all && (w_off != '0) &&
                        (axis_in_next_tkeep[int'(w_off)*NUM_SEG_BYTES +: NUM_SEG_BYTES] == '0);
    assign w_beat     = (r_state == STREAM) && w_free && (w_last ? w_hi_valid : w_all);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= STRIP;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == STRIP)  ? ((w_all && !w_hdr_only) ? STREAM : STRIP)
               : (r_state == STREAM) ? (!w_beat ? STREAM : w_last ? STRIP : w_case_b ? DRAIN : STREAM)
               : (w_hi_valid ? STRIP : DRAIN);
    end

    always_comb begin
        w_pop = (r_state == STRIP)  ? (w_hdr_only ? ALL_LANES : w_all ? w_lo_mask : '0)
              : (r_state == STREAM) ? (w_beat ? (w_last ? w_hi_mask : ALL_LANES) : '0)
              : (w_hi_valid ? w_hi_mask : '0);
        w_tdata = '0;
        w_tkeep = '0;
        for (int i = 0; i < NUM_SEGMENTS; i++) begin
            w_tdata[i*AXIS_SEG_WIDTH +: AXIS_SEG_WIDTH] =
                axis_in_tdata[((i + int'(r_off)) % NUM_SEGMENTS)*AXIS_SEG_WIDTH +: AXIS_SEG_WIDTH];
            w_tkeep[i*NUM_SEG_BYTES +: NUM_SEG_BYTES] = (w_last && (i >= NUM_SEGMENTS - int'(r_off))) ? '0 :
                axis_in_tkeep[((i + int'(r_off)) % NUM_SEGMENTS)*NUM_SEG_BYTES +: NUM_SEG_BYTES];
        end
    end

    assign axis_in_tready = aresetn ? w_pop : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_off       <= '0;
            r_tuser     <= '0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_out_tuser <= '0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
        end else begin
            if (r_state == STRIP) begin
                r_off   <= strip_segs;
                r_tuser <= axis_in_tuser;
            end
            if (w_beat) begin
                r_tvalid    <= 1'b1;
                r_tdata     <= w_tdata;
                r_tkeep     <= w_tkeep;
                r_out_tuser <= r_tuser;
                r_tlast     <= w_last || w_case_b;
            end else if (axis_out_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign axis_out_tdata  = r_tdata;
    assign axis_out_tkeep  = r_tkeep;
    assign axis_out_tuser  = r_out_tuser;
    assign axis_out_tlast  = r_tlast;
    assign axis_out_tvalid = r_tvalid;
endmodule

// File: tb/tb_axis_seg_header_strip.sv
// tb_axis_seg_header_strip: per-lane FIFO model feeding the stripper, checked against a
// segment-list reference (drop leading segments, regroup into beats, trim empty tail beats).
module tb_axis_seg_header_strip;
    localparam int N  = 4;
    localparam int SW = 16;
    localparam int SB = 2;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  k;
        logic        l;
        logic [3:0]  u;
        logic        f;
        logic [1:0]  s;
    } ent_t;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [3:0]  u;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [1:0]  strip_segs = '0;
    logic [63:0] in_tdata = '0;
    logic [7:0]  in_tkeep = '0, in_nkeep = '0;
    logic [3:0]  in_tuser = '0;
    logic        in_tlast = 1'b0;
    logic [3:0]  in_valid = '0, in_ready;
    logic [63:0] out_tdata;
    logic [7:0]  out_tkeep;
    logic [3:0]  out_tuser;
    logic        out_tlast, out_tvalid;
    logic        out_tready = 1'b1;

    ent_t  lq[N][$];
    beat_t expq[$];
    int    n_chk = 0, n_fail = 0;
    int    rdy_mode = 0;
    logic  stall_prev = 1'b0;
    beat_t held;
    logic  obs_valid = 1'b0;
    logic [3:0] obs_ready = '0;

    axis_seg_header_strip dut (
        .aclk(aclk), .aresetn(aresetn), .strip_segs(strip_segs),
        .axis_in_tdata(in_tdata), .axis_in_tkeep(in_tkeep), .axis_in_next_tkeep(in_nkeep),
        .axis_in_tuser(in_tuser), .axis_in_tlast(in_tlast),
        .axis_in_tvalid(in_valid), .axis_in_tready(in_ready),
        .axis_out_tdata(out_tdata), .axis_out_tkeep(out_tkeep), .axis_out_tuser(out_tuser),
        .axis_out_tlast(out_tlast), .axis_out_tvalid(out_tvalid), .axis_out_tready(out_tready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] kmask(input logic [7:0] k);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{k[b]}};
        return m;
    endfunction

    function automatic logic lanes_busy();
        logic busy = 1'b0;
        for (int j = 0; j < N; j++) if (lq[j].size() > 0) busy = 1'b1;
        return busy;
    endfunction

    // Upstream FIFO view: heads of each lane, second entry keep, lane N-1 sideband.
    task automatic drive_lanes();
        in_tdata = '0; in_tkeep = '0; in_nkeep = '0; in_valid = '0;
        in_tuser = '0; in_tlast = 1'b0;
        strip_segs = 2'($urandom);
        for (int j = 0; j < N; j++) begin
            if (lq[j].size() > 0) begin
                in_tdata[j*SW +: SW] = lq[j][0].d;
                in_tkeep[j*SB +: SB] = lq[j][0].k;
                in_valid[j] = 1'b1;
                if (lq[j].size() > 1) in_nkeep[j*SB +: SB] = lq[j][1].k;
            end
        end
        if (lq[N-1].size() > 0) begin
            in_tuser = lq[N-1][0].u;
            in_tlast = lq[N-1][0].l;
            if (lq[N-1][0].f) strip_segs = lq[N-1][0].s;
        end
    endtask

    // Loads a packet into the lanes and appends its expected beats to the scoreboard.
    task automatic push_packet(input int s, input int rows, input int lb, input logic [3:0] u);
        ent_t  sg[$];
        beat_t tmp[$];
        beat_t bt;
        ent_t  e;
        int    total = rows * N;
        for (int r = 0; r < rows; r++) begin
            for (int j = 0; j < N; j++) begin
                e.d = 16'($urandom);
                for (int b = 0; b < SB; b++) e.k[b] = (r < rows - 1) || (j*SB + b < lb);
                e.l = (r == rows - 1);
                e.u = u;
                e.f = (r == 0);
                e.s = 2'(s);
                lq[j].push_back(e);
                sg.push_back(e);
            end
        end
        for (int b = 0; s + b*N < total; b++) begin
            bt = '0;
            bt.u = u;
            for (int k = 0; k < N; k++) begin
                if (s + b*N + k < total) begin
                    bt.d[k*SW +: SW] = sg[s + b*N + k].d;
                    bt.k[k*SB +: SB] = sg[s + b*N + k].k;
                end
            end
            tmp.push_back(bt);
        end
        while (tmp.size() > 0 && tmp[tmp.size()-1].k == '0) void'(tmp.pop_back());
        if (tmp.size() > 0) tmp[tmp.size()-1].l = 1'b1;
        foreach (tmp[i]) expq.push_back(tmp[i]);
        drive_lanes();
    endtask

    task automatic step();
        logic [3:0] pm;
        beat_t e;
        @(negedge aclk);
        obs_valid = out_tvalid;
        obs_ready = in_ready;
        pm = in_ready;
        if (stall_prev) begin
            check("hold_valid", 64'(out_tvalid), 64'(1));
            check("hold_data", out_tdata, held.d);
            check("hold_keep", 64'(out_tkeep), 64'(held.k));
            check("hold_last", 64'(out_tlast), 64'(held.l));
        end
        check("pop_valid", 64'(pm & ~in_valid), 64'(0));
        if (out_tvalid && out_tready) begin
            if (expq.size() == 0) check("extra_beat", 64'(1), 64'(0));
            else begin
                e = expq.pop_front();
                check("beat_keep", 64'(out_tkeep), 64'(e.k));
                check("beat_data", out_tdata & kmask(e.k), e.d & kmask(e.k));
                check("beat_last", 64'(out_tlast), 64'(e.l));
                check("beat_user", 64'(out_tuser), 64'(e.u));
            end
        end
        stall_prev = out_tvalid && !out_tready;
        held.d = out_tdata; held.k = out_tkeep; held.l = out_tlast; held.u = out_tuser;
        @(posedge aclk);
        #1;
        for (int j = 0; j < N; j++) if (pm[j] && lq[j].size() > 0) void'(lq[j].pop_front());
        out_tready = (rdy_mode == 1) ? ($urandom_range(3) != 0) : (rdy_mode == 0);
        drive_lanes();
    endtask

    task automatic run_all(input int budget);
        int n = 0;
        while ((expq.size() > 0 || lanes_busy()) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", 64'(n >= budget), 64'(0));
        repeat (3) step();
    endtask

    initial begin
        int n;
        drive_lanes();
        #12;
        check("rst_valid", 64'(out_tvalid), 64'(0));
        check("rst_data", out_tdata, 64'(0));
        check("rst_keep", 64'(out_tkeep), 64'(0));
        check("rst_last", 64'(out_tlast), 64'(0));
        check("rst_user", 64'(out_tuser), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(0));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (2) step();

        // off=0 pass-through and first-beat latency
        push_packet(0, 3, 8, 4'h5);
        n = 0;
        do begin
            step();
            n++;
        end while (!obs_valid && n < 10);
        check("latency", 64'(n), 64'(3));
        run_all(200);

        // off=1 with Case A tail, off=2 with Case B + DRAIN, then unrotated packet
        push_packet(1, 3, 8, 4'h1);
        run_all(200);
        push_packet(2, 2, 2, 4'h2);
        push_packet(0, 2, 8, 4'h3);
        run_all(200);

        // header-only packet followed by a normal one
        push_packet(2, 1, 4, 4'h6);
        push_packet(1, 2, 8, 4'h7);
        run_all(200);

        // backpressure mid-packet while strip_segs wanders
        push_packet(0, 6, 8, 4'h9);
        n = 0;
        while (expq.size() == 6 && n < 20) begin
            step();
            n++;
        end
        rdy_mode = 2;
        out_tready = 1'b0;
        repeat (5) begin
            step();
            check("stall_ready", 64'(obs_ready), 64'(0));
            check("stall_valid", 64'(obs_valid), 64'(1));
        end
        rdy_mode = 0;
        out_tready = 1'b1;
        run_all(200);

        // randomized back-to-back packets with random backpressure
        rdy_mode = 1;
        for (int it = 0; it < 15; it++) begin
            for (int p = 0; p < 3; p++)
                push_packet($urandom_range(3), $urandom_range(4, 1), $urandom_range(8, 1), 4'($urandom));
            run_all(400);
        end

        // asynchronous reset mid-packet, then a fresh packet
        rdy_mode = 0;
        out_tready = 1'b1;
        push_packet(1, 4, 8, 4'hA);
        repeat (3) step();
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_valid", 64'(out_tvalid), 64'(0));
        check("arst_keep", 64'(out_tkeep), 64'(0));
        check("arst_ready", 64'(in_ready), 64'(0));
        for (int j = 0; j < N; j++) lq[j].delete();
        expq.delete();
        stall_prev = 1'b0;
        drive_lanes();
        repeat (2) step();
        aresetn = 1'b1;
        step();
        push_packet(3, 3, 5, 4'hC);
        run_all(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
